// File: rtl/hazard_ctrl_param_if.sv
// Decode/fetch control bundle for hazard_ctrl_param.
// Optional forwarding signals exist only when HAZARD_FWD_EN is defined.
interface hazard_ctrl_param_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*REG_AW-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_used;
    logic [REG_AW-1:0]         reg_ex;
    logic                      reg_ex_en;
    logic [REG_AW-1:0]         reg_wb;
    logic                      reg_wb_en;
    logic                      branch_miss;
    logic                      int_req;
    logic                      int_en;
    logic                      fetch_latch_en;
    logic                      pc_inc;
    logic                      pc_load;
    logic                      imem_addr_mux;
    logic                      dec_nop;
    logic                      ex_bubble;
    logic                      int_ack;
    // Current controller state: 0 CHECK, 1 RAW_STALL, 2 FLUSH, 3 INT_ENTRY.
    logic [1:0]                state;
`ifdef HAZARD_FWD_EN
    logic                      reg_ex_is_load;
    logic [2*NUM_SRC-1:0]      fwd_sel;
`endif

    // All control outputs are level signals evaluated every cycle; there is
    // no valid/ready handshake, the pipeline acts on them in the same cycle.
    modport master (
        output src_addr, src_used, reg_ex, reg_ex_en, reg_wb, reg_wb_en,
               branch_miss, int_req, int_en,
`ifdef HAZARD_FWD_EN
               reg_ex_is_load,
        input  fwd_sel,
`endif
        input  fetch_latch_en, pc_inc, pc_load, imem_addr_mux, dec_nop,
               ex_bubble, int_ack, state
    );

    modport slave (
        input  src_addr, src_used, reg_ex, reg_ex_en, reg_wb, reg_wb_en,
               branch_miss, int_req, int_en,
`ifdef HAZARD_FWD_EN
               reg_ex_is_load,
        output fwd_sel,
`endif
        output fetch_latch_en, pc_inc, pc_load, imem_addr_mux, dec_nop,
               ex_bubble, int_ack, state
    );
endinterface

// File: rtl/hazard_ctrl_param.sv
// Parametrised pipeline hazard controller: RAW stalls, mispredict flush, interrupt entry.
// Define HAZARD_FWD_EN to add operand forwarding (fwd_sel) and load-use-only stalls.
module hazard_ctrl_param #(
    parameter int REG_AW        = 5,
    parameter int NUM_SRC       = 2,
    parameter int RAW_EX_CYCLES = 1,
    parameter int FLUSH_CYCLES  = 2
) (
    input logic                  clk,
    input logic                  reset,
    hazard_ctrl_param_if.slave   bus
);
    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        RAW_STALL = 2'd1,
        FLUSH     = 2'd2,
        INT_ENTRY = 2'd3
    } state_t;

    localparam logic [2:0] RAW_RELOAD   = 3'(RAW_EX_CYCLES - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t             state, state_nxt;
    logic [2:0]         cnt, cnt_nxt;
    logic [NUM_SRC-1:0] ex_hit, wb_hit;
    logic               stall_ex, stall_wb, stall;

    always_comb begin
        ex_hit = '0;
        wb_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ex_hit[i] = bus.src_used[i] && bus.reg_ex_en &&
                        (bus.src_addr[i*REG_AW +: REG_AW] == bus.reg_ex);
            wb_hit[i] = bus.src_used[i] && bus.reg_wb_en &&
                        (bus.src_addr[i*REG_AW +: REG_AW] == bus.reg_wb);
        end
    end

`ifdef HAZARD_FWD_EN
    // EX is the younger producer, so it wins when both stages match.
    always_comb begin
        bus.fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_hit[i])      bus.fwd_sel[2*i +: 2] = 2'b01;
            else if (wb_hit[i]) bus.fwd_sel[2*i +: 2] = 2'b10;
        end
    end

    assign stall_ex = (|ex_hit) && bus.reg_ex_is_load;
    assign stall_wb = 1'b0;
`else
    assign stall_ex = |ex_hit;
    assign stall_wb = |wb_hit;
`endif

    assign stall = stall_ex || stall_wb || (state == RAW_STALL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CHECK;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CHECK: begin
                if (bus.branch_miss) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_RELOAD;
                end else if (bus.int_req && bus.int_en) begin
                    state_nxt = INT_ENTRY;
                end else if (stall_ex) begin
                    state_nxt = RAW_STALL;
                    cnt_nxt   = RAW_RELOAD;
                end
            end
            RAW_STALL: begin
                if (bus.branch_miss) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_RELOAD;
                end else if (cnt == 3'd0) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            FLUSH: begin
                if (bus.branch_miss) begin
                    cnt_nxt = FLUSH_RELOAD;
                end else if (cnt == 3'd0) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            INT_ENTRY: begin
                state_nxt = CHECK;
            end
            default: begin
                state_nxt = CHECK;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Reset gates the outputs combinationally so the pipeline is quiesced
    // the moment reset asserts, not at the next edge.
    always_comb begin
        bus.pc_load        = 1'b0;
        bus.imem_addr_mux  = 1'b0;
        bus.dec_nop        = 1'b1;
        bus.ex_bubble      = 1'b0;
        bus.fetch_latch_en = 1'b0;
        bus.pc_inc         = 1'b0;
        bus.int_ack        = 1'b0;
        if (reset) begin
            bus.pc_load        = bus.branch_miss || (state == INT_ENTRY);
            bus.imem_addr_mux  = (state == INT_ENTRY) && !bus.branch_miss;
            bus.dec_nop        = bus.branch_miss || (state == FLUSH) ||
                                 (state == INT_ENTRY);
            bus.ex_bubble      = stall && !bus.dec_nop;
            bus.fetch_latch_en = !stall || bus.pc_load;
            bus.pc_inc         = !stall && !bus.pc_load;
            bus.int_ack        = (state == INT_ENTRY);
        end
    end

    assign bus.state = state;
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed bench for hazard_ctrl_param (RAW_EX_CYCLES=2, FLUSH_CYCLES=2).
// Output vector order: {fetch_latch_en, pc_inc, pc_load, imem_addr_mux, dec_nop, ex_bubble, int_ack}.
module tb_hazard_ctrl_param;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;

    localparam logic [1:0] S_CHECK = 2'd0;
    localparam logic [1:0] S_RAW   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_INT   = 2'd3;

    localparam logic [6:0] O_RESET  = 7'b0000100;
    localparam logic [6:0] O_RUN    = 7'b1100000;
    localparam logic [6:0] O_STALL  = 7'b0000010;
    localparam logic [6:0] O_BRANCH = 7'b1010100;
    localparam logic [6:0] O_FLUSH  = 7'b1100100;
    localparam logic [6:0] O_INT    = 7'b1011101;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    hazard_ctrl_param_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) bus ();

    hazard_ctrl_param #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .RAW_EX_CYCLES(2), .FLUSH_CYCLES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] outs;
    assign outs = {bus.fetch_latch_en, bus.pc_inc, bus.pc_load, bus.imem_addr_mux,
                   bus.dec_nop, bus.ex_bubble, bus.int_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic [6:0] exp_o, input logic [1:0] exp_s);
        #1;
        check({tag, "_out"}, 32'(outs), 32'(exp_o));
        check({tag, "_st"}, 32'(bus.state), 32'(exp_s));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.src_addr    = '0;
        bus.src_used    = '0;
        bus.reg_ex      = '0;
        bus.reg_ex_en   = 1'b0;
        bus.reg_wb      = '0;
        bus.reg_wb_en   = 1'b0;
        bus.branch_miss = 1'b0;
        bus.int_req     = 1'b0;
        bus.int_en      = 1'b0;
`ifdef HAZARD_FWD_EN
        bus.reg_ex_is_load = 1'b1;
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        idle();
        expect_cycle("reset_hold", O_RESET, S_CHECK);
        step();
        reset = 1'b1;
        expect_cycle("reset_rel", O_RUN, S_CHECK);
        step();

        // Reset asserted in the middle of a flush.
        bus.branch_miss = 1'b1;
        expect_cycle("rstfl_bm", O_BRANCH, S_CHECK);
        step();
        bus.branch_miss = 1'b0;
        expect_cycle("rstfl_fl", O_FLUSH, S_FLUSH);
        reset = 1'b0;
        expect_cycle("rstfl_async", O_RESET, S_CHECK);
        step();
        reset = 1'b1;
        expect_cycle("rstfl_rel", O_RUN, S_CHECK);
        step();
        expect_cycle("rstfl_stay", O_RUN, S_CHECK);

        // RAW against EX: detect cycle plus two RAW_STALL cycles.
        bus.src_addr  = {5'd3, 5'd7};
        bus.src_used  = 2'b11;
        bus.reg_ex    = 5'd7;
        bus.reg_ex_en = 1'b1;
        expect_cycle("raw_det", O_STALL, S_CHECK);
        step();
        bus.reg_ex_en = 1'b0;
        expect_cycle("raw_s1", O_STALL, S_RAW);
        step();
        expect_cycle("raw_s2", O_STALL, S_RAW);
        step();
        expect_cycle("raw_done", O_RUN, S_CHECK);

        // Unused operand matches EX: no hazard.
        bus.src_addr  = {5'd9, 5'd4};
        bus.src_used  = 2'b01;
        bus.reg_ex    = 5'd9;
        bus.reg_ex_en = 1'b1;
        expect_cycle("unused_op", O_RUN, S_CHECK);
`ifdef HAZARD_FWD_EN
        check("unused_fwd", 32'(bus.fwd_sel), 32'h0);
`endif
        step();

        // RAW against WB: stalls this cycle only (no stall when forwarding).
        bus.reg_ex_en = 1'b0;
        bus.src_addr  = {5'd9, 5'd3};
        bus.reg_wb    = 5'd3;
        bus.reg_wb_en = 1'b1;
`ifdef HAZARD_FWD_EN
        expect_cycle("wb_det", O_RUN, S_CHECK);
        check("wb_fwd", 32'(bus.fwd_sel), 32'h2);
`else
        expect_cycle("wb_det", O_STALL, S_CHECK);
`endif
        step();
        bus.reg_wb_en = 1'b0;
        expect_cycle("wb_after", O_RUN, S_CHECK);
        idle();
        step();

        // Branch mispredict: load cycle, then two flush cycles.
        bus.branch_miss = 1'b1;
        expect_cycle("br_load", O_BRANCH, S_CHECK);
        step();
        bus.branch_miss = 1'b0;
        expect_cycle("br_fl1", O_FLUSH, S_FLUSH);
        step();
        expect_cycle("br_fl2", O_FLUSH, S_FLUSH);
        step();
        expect_cycle("br_done", O_RUN, S_CHECK);

        // Interrupt raised during RAW_STALL waits for CHECK.
        bus.src_addr  = {5'd3, 5'd7};
        bus.src_used  = 2'b11;
        bus.reg_ex    = 5'd7;
        bus.reg_ex_en = 1'b1;
        expect_cycle("irs_det", O_STALL, S_CHECK);
        step();
        bus.reg_ex_en = 1'b0;
        bus.int_req   = 1'b1;
        bus.int_en    = 1'b1;
        expect_cycle("irs_s1", O_STALL, S_RAW);
        step();
        expect_cycle("irs_s2", O_STALL, S_RAW);
        step();
        expect_cycle("irs_chk", O_RUN, S_CHECK);
        step();
        expect_cycle("irs_ent", O_INT, S_INT);
        bus.int_req = 1'b0;
        step();
        expect_cycle("irs_done", O_RUN, S_CHECK);
        idle();
        step();

        // Mispredict and interrupt together: flush first, then interrupt.
        bus.branch_miss = 1'b1;
        bus.int_req     = 1'b1;
        bus.int_en      = 1'b1;
        expect_cycle("bi_load", O_BRANCH, S_CHECK);
        step();
        bus.branch_miss = 1'b0;
        expect_cycle("bi_fl1", O_FLUSH, S_FLUSH);
        step();
        expect_cycle("bi_fl2", O_FLUSH, S_FLUSH);
        step();
        expect_cycle("bi_chk", O_RUN, S_CHECK);
        step();
        expect_cycle("bi_ent", O_INT, S_INT);
        bus.int_req = 1'b0;
        step();
        expect_cycle("bi_done", O_RUN, S_CHECK);

        // Mispredict inside FLUSH reloads the counter.
        bus.branch_miss = 1'b1;
        step();
        bus.branch_miss = 1'b0;
        step();
        bus.branch_miss = 1'b1;
        expect_cycle("rl_bm", O_BRANCH, S_FLUSH);
        step();
        bus.branch_miss = 1'b0;
        expect_cycle("rl_fl1", O_FLUSH, S_FLUSH);
        step();
        expect_cycle("rl_fl2", O_FLUSH, S_FLUSH);
        step();
        expect_cycle("rl_done", O_RUN, S_CHECK);

`ifdef HAZARD_FWD_EN
        // Non-load producer in EX: forwarded, no stall.
        bus.src_addr       = {5'd3, 5'd7};
        bus.src_used       = 2'b11;
        bus.reg_ex         = 5'd7;
        bus.reg_ex_en      = 1'b1;
        bus.reg_ex_is_load = 1'b0;
        expect_cycle("fwd_ex", O_RUN, S_CHECK);
        check("fwd_ex_sel", 32'(bus.fwd_sel), 32'h1);
        step();
        expect_cycle("fwd_ex_stay", O_RUN, S_CHECK);
`endif

        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
- Parametrised successor to the fixed two-operand pipeline hazard controller.
- Sits between decode and fetch. Compares NUM_SRC decode source registers against the EX and WB destinations.
- Issues stalls, bubbles, flushes and PC-load control for branch mispredicts and interrupt entry.
- Timing is fully sequenced by a state machine with down-counters: stall and flush lengths are parameters, not hard-wired.

Parameters:
- REG_AW, 5, register address width
- NUM_SRC, 2, number of decode source operands checked (1..4)
- RAW_EX_CYCLES, 1, stall cycles for a RAW hazard against EX (1..7)
- FLUSH_CYCLES, 2, decode-nop cycles after a mispredict (1..7)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- src_addr  in  NUM_SRC*REG_AW  packed decode source addresses; operand i at [i*REG_AW +: REG_AW]
- src_used  in  NUM_SRC  operand i valid
- reg_ex  in  REG_AW  EX destination
- reg_ex_en  in  1  EX writes reg_ex
- reg_wb  in  REG_AW  WB destination
- reg_wb_en  in  1  WB writes reg_wb
- branch_miss  in  1  EX resolved a mispredict this cycle
- int_req  in  1  level interrupt request
- int_en  in  1  interrupts enabled
- fetch_latch_en  out  1  fetch/decode latch load enable
- pc_inc  out  1  PC increment
- pc_load  out  1  PC parallel load
- imem_addr_mux  out  1  0 = branch target, 1 = interrupt vector
- dec_nop  out  1  replace decode output with NOP (flush)
- ex_bubble  out  1  insert bubble into EX (stall)
- int_ack  out  1  one-cycle interrupt acknowledge

Behaviour:
- Hazard terms:
  - raw_ex = OR over i of (src_used[i] && src_addr_i==reg_ex && reg_ex_en).
  - raw_wb is the same against reg_wb/reg_wb_en.
  - stall = raw_ex || raw_wb || state==RAW_STALL.
- States and counter:
  - States: CHECK, RAW_STALL, FLUSH, INT_ENTRY.
  - cnt is 3-bit; it reloads on entry to a state and decrements in that state.
- CHECK transitions, priority high to low:
  - branch_miss: go to FLUSH, cnt=FLUSH_CYCLES-1.
  - int_req&&int_en: go to INT_ENTRY.
  - raw_ex: go to RAW_STALL, cnt=RAW_EX_CYCLES-1.
  - else stay in CHECK.
- RAW_STALL:
  - branch_miss aborts the stall and goes to FLUSH.
  - Otherwise return to CHECK when cnt==0, else decrement.
- FLUSH: return to CHECK when cnt==0, else decrement. branch_miss inside FLUSH reloads cnt=FLUSH_CYCLES-1.
- INT_ENTRY: lasts exactly one cycle, then CHECK. int_ack=1 in this state only.
- int_req seen in RAW_STALL/FLUSH stays pending (level input) and is taken on the first CHECK cycle with no branch_miss.
- Outputs are combinational from state and inputs:
  - pc_load = branch_miss || state==INT_ENTRY.
  - imem_addr_mux = (state==INT_ENTRY) && !branch_miss.
  - dec_nop = branch_miss || state==FLUSH || state==INT_ENTRY.
  - ex_bubble = stall && !dec_nop.
  - fetch_latch_en = !stall || pc_load.
  - pc_inc = !stall && !pc_load.
- pc_load and pc_inc are never both 1.
- raw_wb only stalls for the current cycle and never enters RAW_STALL; it assumes a write-first register file one cycle later.
- Reset low, asynchronous:
  - state=CHECK, cnt=0.
  - While reset is held: dec_nop=1; fetch_latch_en, pc_inc, pc_load, imem_addr_mux, ex_bubble and int_ack are all 0.
  - Release takes effect at the next clk edge.
  - Reset asserted mid-FLUSH or mid-stall aborts immediately; no pending state survives.

Optional Feature:
- Macro HAZARD_FWD_EN.
- Defined:
  - Adds outputs fwd_sel [2*NUM_SRC-1:0]: per operand 2'b01 = forward from EX, 2'b10 = forward from WB; EX wins if both match.
  - Adds input reg_ex_is_load.
  - raw_ex stalls only when reg_ex_is_load=1 (load-use); raw_wb never stalls.
- Undefined: fwd_sel and reg_ex_is_load are absent, and stall behaviour is exactly as above.

Test Plan:
- Reset low mid-FLUSH (cnt=1) -> outputs immediately dec_nop=1, pc_inc=0. After release, the first cycle shows pc_inc=1, fetch_latch_en=1, state CHECK.
- src_addr={5'd3,5'd7}, src_used=2'b11, reg_ex=7, reg_ex_en=1, RAW_EX_CYCLES=2 -> ex_bubble=1, pc_inc=0, fetch_latch_en=0 for 3 cycles (detect + 2 state), then pc_inc=1.
- src_used=2'b01, src_addr op1=9, reg_ex=9 -> no stall. Same with reg_wb=3, reg_wb_en=1, op0=3 -> single-cycle stall, no RAW_STALL entry.
- branch_miss pulse in CHECK, FLUSH_CYCLES=2 -> cycle 0: pc_load=1, imem_addr_mux=0, dec_nop=1. dec_nop=1 for 2 further cycles, then 0.
- int_req=1, int_en=1 during RAW_STALL -> no int_ack until CHECK. Then int_ack=1, pc_load=1, imem_addr_mux=1 for exactly one cycle.
- branch_miss and int_req in the same CHECK cycle -> FLUSH entered, int_ack delayed until after FLUSH completes. With HAZARD_FWD_EN and reg_ex_is_load=0 on a raw_ex -> fwd_sel op=2'b01, no stall.
